load_split_unit: RTL and testbench

- Sequential load-data unit between the memory-stage load path and the data-memory read port.
- Accepts one load request (funct3, byte address) at a time and issues one or two word-aligned memory reads.
- Misaligned halfword/word loads are split into two beats and merged.
- Returns the sign/zero-extended result over a valid/ready response channel, with fault flags.

---
 rtl/load_split_if.sv | 36 +++
 rtl/load_split_unit.sv | 139 +++++++++++++
 tb/tb_load_split_unit.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/load_split_if.sv
// Load-split unit bus bundle: request channel, data-memory read port and response channel.
// The unit connects through the slave modport; the requester/memory side uses master.
interface load_split_if #(
  parameter int ADDR_W = 32
);
  logic              i_req_valid;
  logic              o_req_ready;
  logic [2:0]        i_req_funct3;
  logic [ADDR_W-1:0] i_req_addr;
  logic              o_mem_valid;
  logic              i_mem_ready;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              i_mem_rvalid;
  logic [31:0]       i_mem_rdata;
  logic              i_mem_err;
  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic [31:0]       o_rsp_data;
  logic              o_rsp_err;
  logic              o_rsp_misalign;
  logic              o_rsp_illegal;

  modport slave (
    input  i_req_valid, i_req_funct3, i_req_addr,
    input  i_mem_ready, i_mem_rvalid, i_mem_rdata, i_mem_err, i_rsp_ready,
    output o_req_ready, o_mem_valid, o_mem_addr,
    output o_rsp_valid, o_rsp_data, o_rsp_err, o_rsp_misalign, o_rsp_illegal
  );

  modport master (
    output i_req_valid, i_req_funct3, i_req_addr,
    output i_mem_ready, i_mem_rvalid, i_mem_rdata, i_mem_err, i_rsp_ready,
    input  o_req_ready, o_mem_valid, o_mem_addr,
    input  o_rsp_valid, o_rsp_data, o_rsp_err, o_rsp_misalign, o_rsp_illegal
  );
endinterface

// File: rtl/load_split_unit.sv
// Load-data unit: issues one or two word-aligned reads per load, merges split beats,
// and returns the sign/zero-extended result with error/misalign/illegal flags.
module load_split_unit #(
  parameter int ADDR_W         = 32,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input logic         clk,
  input logic         rst,
  load_split_if.slave bus
);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

  state_t            state;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       beat0_q;
  logic              mem_valid_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_data_q;
  logic              rsp_err_q;
  logic              rsp_misalign_q;
  logic              rsp_illegal_q;

  function automatic logic is_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && (off == 2'b11)) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

  // Shift the {hi, lo} byte stream down to the access offset, then extend by size/sign.
  function automatic logic [31:0] merge_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] hi, input logic [31:0] lo);
    logic [31:0]        w;
    logic signed [31:0] ext;
    w = 32'({hi, lo} >> {off, 3'b000});
    case (f3[1:0])
      2'b00:   ext = f3[2] ? {24'd0, w[7:0]}  : 32'($signed(w[7:0]));
      2'b01:   ext = f3[2] ? {16'd0, w[15:0]} : 32'($signed(w[15:0]));
      default: ext = w;
    endcase
    return ext;
  endfunction

  // Request context and first beat are plain data: no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.i_req_valid) begin
      funct3_q <= bus.i_req_funct3;
      off_q    <= bus.i_req_addr[1:0];
      base_q   <= {bus.i_req_addr[ADDR_W-1:2], 2'b00};
    end
    if (state == WAIT0 && bus.i_mem_rvalid) beat0_q <= bus.i_mem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      mem_valid_q    <= 1'b0;
      mem_addr_q     <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_err_q      <= 1'b0;
      rsp_misalign_q <= 1'b0;
      rsp_illegal_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.i_req_valid) begin
          if (is_illegal(bus.i_req_funct3)) begin
            state         <= RESP;
            rsp_valid_q   <= 1'b1;
            rsp_illegal_q <= 1'b1;
          end else if (!MISALIGN_SPLIT &&
                       is_misaligned(bus.i_req_funct3, bus.i_req_addr[1:0])) begin
            state          <= RESP;
            rsp_valid_q    <= 1'b1;
            rsp_misalign_q <= 1'b1;
          end else begin
            state       <= REQ0;
            mem_valid_q <= 1'b1;
            mem_addr_q  <= {bus.i_req_addr[ADDR_W-1:2], 2'b00};
          end
        end
        REQ0: if (bus.i_mem_ready) begin
          state       <= WAIT0;
          mem_valid_q <= 1'b0;
        end
        WAIT0: if (bus.i_mem_rvalid) begin
          if (bus.i_mem_err) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end else if (is_misaligned(funct3_q, off_q)) begin
            state       <= REQ1;
            mem_valid_q <= 1'b1;
            mem_addr_q  <= base_q + ADDR_W'(4);
          end else begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= merge_load(funct3_q, off_q, 32'd0, bus.i_mem_rdata);
          end
        end
        REQ1: if (bus.i_mem_ready) begin
          state       <= WAIT1;
          mem_valid_q <= 1'b0;
        end
        WAIT1: if (bus.i_mem_rvalid) begin
          state       <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= bus.i_mem_err;
          rsp_data_q  <= bus.i_mem_err ? 32'd0
                                       : merge_load(funct3_q, off_q, bus.i_mem_rdata, beat0_q);
        end
        RESP: if (bus.i_rsp_ready) begin
          state          <= IDLE;
          rsp_valid_q    <= 1'b0;
          rsp_data_q     <= '0;
          rsp_err_q      <= 1'b0;
          rsp_misalign_q <= 1'b0;
          rsp_illegal_q  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_req_ready    = (state == IDLE);
  assign bus.o_mem_valid    = mem_valid_q;
  assign bus.o_mem_addr     = mem_addr_q;
  assign bus.o_rsp_valid    = rsp_valid_q;
  assign bus.o_rsp_data     = rsp_data_q;
  assign bus.o_rsp_err      = rsp_err_q;
  assign bus.o_rsp_misalign = rsp_misalign_q;
  assign bus.o_rsp_illegal  = rsp_illegal_q;

endmodule

// File: tb/tb_load_split_unit.sv
// Directed bench for load_split_unit: a split-enabled and a split-disabled instance
// driven from one stimulus table, plus hand-written reset-in-flight sequence.
module tb_load_split_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  f3 = 3'b000;
  logic [31:0] addr = 32'd0;
  logic        mem_ready = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic        mem_err = 1'b0;
  logic        rsp_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_split_if #(.ADDR_W(32)) b1 ();
  load_split_if #(.ADDR_W(32)) b2 ();

  assign b1.i_req_valid  = req_valid & ~sel;
  assign b2.i_req_valid  = req_valid & sel;
  assign b1.i_req_funct3 = f3;
  assign b2.i_req_funct3 = f3;
  assign b1.i_req_addr   = addr;
  assign b2.i_req_addr   = addr;
  assign b1.i_mem_ready  = mem_ready;
  assign b2.i_mem_ready  = mem_ready;
  assign b1.i_mem_rvalid = rvalid;
  assign b2.i_mem_rvalid = rvalid;
  assign b1.i_mem_rdata  = rdata;
  assign b2.i_mem_rdata  = rdata;
  assign b1.i_mem_err    = mem_err;
  assign b2.i_mem_err    = mem_err;
  assign b1.i_rsp_ready  = rsp_ready;
  assign b2.i_rsp_ready  = rsp_ready;

  load_split_unit #(.ADDR_W(32), .MISALIGN_SPLIT(1'b1)) u_split (
    .clk(clk), .rst(rst), .bus(b1.slave));
  load_split_unit #(.ADDR_W(32), .MISALIGN_SPLIT(1'b0)) u_nosplit (
    .clk(clk), .rst(rst), .bus(b2.slave));

  logic        req_ready_m, mem_valid_m, rsp_valid_m, err_m, mis_m, ill_m;
  logic [31:0] mem_addr_m, data_m;
  assign req_ready_m = sel ? b2.o_req_ready    : b1.o_req_ready;
  assign mem_valid_m = sel ? b2.o_mem_valid    : b1.o_mem_valid;
  assign mem_addr_m  = sel ? b2.o_mem_addr     : b1.o_mem_addr;
  assign rsp_valid_m = sel ? b2.o_rsp_valid    : b1.o_rsp_valid;
  assign data_m      = sel ? b2.o_rsp_data     : b1.o_rsp_data;
  assign err_m       = sel ? b2.o_rsp_err      : b1.o_rsp_err;
  assign mis_m       = sel ? b2.o_rsp_misalign : b1.o_rsp_misalign;
  assign ill_m       = sel ? b2.o_rsp_illegal  : b1.o_rsp_illegal;

  typedef struct {
    bit          s;
    logic [2:0]  f;
    logic [31:0] a, r0, r1;
    bit          e0, e1;
    int          ms, rs, nq;
    logic [31:0] x0, x1, d;
    bit          xe, xi, xm;
    int          lat;
  } vec_t;

  function automatic vec_t mk(bit s, logic [2:0] f, logic [31:0] a, logic [31:0] r0,
                              logic [31:0] r1, bit e0, bit e1, int ms, int rs, int nq,
                              logic [31:0] x0, logic [31:0] x1, logic [31:0] d,
                              bit xe, bit xi, bit xm, int lat);
    vec_t v;
    v.s = s; v.f = f; v.a = a; v.r0 = r0; v.r1 = r1; v.e0 = e0; v.e1 = e1;
    v.ms = ms; v.rs = rs; v.nq = nq; v.x0 = x0; v.x1 = x1; v.d = d;
    v.xe = xe; v.xi = xi; v.xm = xm; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drives one load, plays the memory with optional stalls, checks every response cycle.
  task automatic run_vec(input vec_t t, input string nm);
    int  c, nreq, lat, sm, sr;
    bit  pend, done;
    nreq = 0; lat = -1; sm = t.ms; sr = t.rs; pend = 0; done = 0;
    @(negedge clk);
    sel = t.s; f3 = t.f; addr = t.a; req_valid = 1'b1;
    mem_ready = 1'b0; rsp_ready = 1'b0; rvalid = 1'b0;
    chk({nm, "_idle_ready"}, 32'(req_ready_m), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk({nm, "_busy_ready"}, 32'(req_ready_m), 32'd0);
    c = 1;
    while (!done && c <= 60) begin
      rvalid = 1'b0; rdata = 32'd0; mem_err = 1'b0; mem_ready = 1'b0; rsp_ready = 1'b0;
      if (pend) begin
        rvalid  = 1'b1;
        rdata   = (nreq == 1) ? t.r0 : t.r1;
        mem_err = (nreq == 1) ? t.e0 : t.e1;
        pend    = 0;
      end
      if (mem_valid_m) begin
        if (nreq >= t.nq) chk({nm, "_extra_req"}, 32'(nreq), 32'(t.nq - 1));
        else chk({nm, "_mem_addr"}, mem_addr_m, (nreq == 0) ? t.x0 : t.x1);
        if (nreq == 0 && sm > 0) sm--;
        else begin mem_ready = 1'b1; nreq++; pend = 1; end
      end
      if (rsp_valid_m) begin
        if (lat < 0) lat = c;
        chk({nm, "_data"},     data_m,       t.d);
        chk({nm, "_err"},      32'(err_m),   32'(t.xe));
        chk({nm, "_illegal"},  32'(ill_m),   32'(t.xi));
        chk({nm, "_misalign"}, 32'(mis_m),   32'(t.xm));
        if (sr > 0) sr--;
        else begin rsp_ready = 1'b1; done = 1; end
      end
      @(negedge clk);
      c++;
    end
    rsp_ready = 1'b0; rvalid = 1'b0; mem_err = 1'b0;
    chk({nm, "_completed"}, 32'(done), 32'd1);
    chk({nm, "_latency"},   32'(lat),  32'(t.lat));
    chk({nm, "_nreq"},      32'(nreq), 32'(t.nq));
    chk({nm, "_rsp_drop"},  32'(rsp_valid_m), 32'd0);
    chk({nm, "_back_idle"}, 32'(req_ready_m), 32'd1);
  endtask

  vec_t vecs[$];

  initial begin
    // split-enabled instance (s=0)
    vecs.push_back(mk(0, 3'b010, 32'h100, 32'h8899AABB, 0, 0, 0, 0, 0, 1, 32'h100, 0, 32'h8899AABB, 0, 0, 0, 3));
    vecs.push_back(mk(0, 3'b000, 32'h103, 32'h80112233, 0, 0, 0, 0, 0, 1, 32'h100, 0, 32'hFFFFFF80, 0, 0, 0, 3));
    vecs.push_back(mk(0, 3'b100, 32'h103, 32'h80112233, 0, 0, 0, 0, 0, 1, 32'h100, 0, 32'h00000080, 0, 0, 0, 3));
    vecs.push_back(mk(0, 3'b010, 32'h102, 32'h44332211, 32'h88776655, 0, 0, 0, 0, 2, 32'h100, 32'h104, 32'h66554433, 0, 0, 0, 5));
    vecs.push_back(mk(0, 3'b001, 32'h103, 32'h44332211, 32'h88776655, 0, 0, 0, 0, 2, 32'h100, 32'h104, 32'h00005544, 0, 0, 0, 5));
    vecs.push_back(mk(0, 3'b101, 32'hFFFFFFFF, 32'hAB000000, 32'h000000CD, 0, 0, 0, 0, 2, 32'hFFFFFFFC, 32'h0, 32'h0000CDAB, 0, 0, 0, 5));
    vecs.push_back(mk(0, 3'b001, 32'h203, 32'hF0000000, 32'h00000081, 0, 0, 0, 0, 2, 32'h200, 32'h204, 32'hFFFF81F0, 0, 0, 0, 5));
    vecs.push_back(mk(0, 3'b010, 32'h303, 32'h11000000, 32'h00443322, 0, 0, 0, 0, 2, 32'h300, 32'h304, 32'h44332211, 0, 0, 0, 5));
    vecs.push_back(mk(0, 3'b001, 32'h102, 32'h80001234, 0, 0, 0, 0, 0, 1, 32'h100, 0, 32'hFFFF8000, 0, 0, 0, 3));
    vecs.push_back(mk(0, 3'b101, 32'h101, 32'h00ABCD00, 0, 0, 0, 0, 0, 1, 32'h100, 0, 32'h0000ABCD, 0, 0, 0, 3));
    vecs.push_back(mk(0, 3'b000, 32'h100, 32'h0000007F, 0, 0, 0, 0, 0, 1, 32'h100, 0, 32'h0000007F, 0, 0, 0, 3));
    vecs.push_back(mk(0, 3'b010, 32'h102, 32'h44332211, 0, 1, 0, 0, 0, 1, 32'h100, 0, 32'h0, 1, 0, 0, 3));
    vecs.push_back(mk(0, 3'b010, 32'h101, 32'h44332211, 32'h88776655, 0, 1, 0, 0, 2, 32'h100, 32'h104, 32'h0, 1, 0, 0, 5));
    vecs.push_back(mk(0, 3'b011, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 3'b111, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 3'b010, 32'h102, 32'h44332211, 32'h88776655, 0, 0, 5, 3, 2, 32'h100, 32'h104, 32'h66554433, 0, 0, 0, 10));
    // split-disabled instance (s=1)
    vecs.push_back(mk(1, 3'b010, 32'h101, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 3'b001, 32'h103, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 3'b000, 32'h103, 32'h7F000000, 0, 0, 0, 0, 0, 1, 32'h100, 0, 32'h0000007F, 0, 0, 0, 3));
    vecs.push_back(mk(1, 3'b001, 32'h102, 32'h12340000, 0, 0, 0, 0, 0, 1, 32'h100, 0, 32'h00001234, 0, 0, 0, 3));

    repeat (2) @(negedge clk);
    chk("reset_req_ready", 32'(b1.o_req_ready), 32'd1);
    chk("reset_mem_valid", 32'(b1.o_mem_valid), 32'd0);
    chk("reset_mem_addr",  b1.o_mem_addr,       32'd0);
    chk("reset_rsp_valid", 32'(b1.o_rsp_valid), 32'd0);
    chk("reset_rsp_data",  b1.o_rsp_data,       32'd0);
    chk("reset_flags", {29'd0, b1.o_rsp_err, b1.o_rsp_misalign, b1.o_rsp_illegal}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while waiting for the second beat of a split LW.
    @(negedge clk);
    sel = 1'b0; f3 = 3'b010; addr = 32'h102; req_valid = 1'b1;
    mem_ready = 1'b0; rvalid = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; mem_ready = 1'b1;
    chk("rst_seq_req0_valid", 32'(mem_valid_m), 32'd1);
    @(negedge clk);
    mem_ready = 1'b0; rvalid = 1'b1; rdata = 32'h44332211; mem_err = 1'b0;
    @(negedge clk);
    rvalid = 1'b0; mem_ready = 1'b1;
    chk("rst_seq_req1_addr", mem_addr_m, 32'h104);
    @(negedge clk);
    mem_ready = 1'b0;
    chk("rst_seq_wait1_idle", 32'(rsp_valid_m | mem_valid_m | req_ready_m), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_mem_valid", 32'(mem_valid_m), 32'd0);
    chk("rst_async_mem_addr",  mem_addr_m,       32'd0);
    chk("rst_async_rsp_valid", 32'(rsp_valid_m), 32'd0);
    chk("rst_async_req_ready", 32'(req_ready_m), 32'd1);
    @(negedge clk);
    rst = 1'b0; rvalid = 1'b1; rdata = 32'h88776655;
    @(negedge clk);
    rvalid = 1'b0;
    chk("late_rvalid_rsp_valid", 32'(rsp_valid_m), 32'd0);
    chk("late_rvalid_mem_valid", 32'(mem_valid_m), 32'd0);
    chk("late_rvalid_req_ready", 32'(req_ready_m), 32'd1);
    run_vec(mk(0, 3'b010, 32'h100, 32'h8899AABB, 0, 0, 0, 0, 0, 1, 32'h100, 0, 32'h8899AABB, 0, 0, 0, 3),
            "post_reset_lw");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
